// File: rtl/data_sram_port.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_port
// Purpose  : Request-side master for the data SRAM. Accepts one load/store
//            request from EX, aligns store data into byte lanes, generates
//            byte strobes, and runs an address-phase / data-phase handshake.
//            The pipeline is held through stallreq until the memory answers.
//            The raw read word is returned with the request's size and
//            offset; MEM does extraction and sign extension. Misaligned
//            requests raise an address-error pulse and never reach memory.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req_*                    - request from EX
//            data_sram_* (out)        - address-phase request fields
//            data_sram_addr_ok/data_ok/rdata - memory answers
//            stallreq                 - freeze IF..EX
//            resp_*                   - one-cycle completion with raw word
//            exc_adel/exc_ades/exc_badvaddr - misaligned-access fault
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_size,
  output logic [1:0]  resp_off,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        adel_q;
  logic        ades_q;
  logic [31:0] badvaddr_q;

  logic        misaligned;
  logic        accept;
  logic        fault;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  // Alignment check, strobe and lane-replication for the incoming request.
  // Size 3 behaves exactly like a word access.
  always_comb begin
    misaligned = 1'b0;
    wstrb_d    = 4'b1111;
    wdata_d    = req_wdata;
    case (req_size)
      2'd0: begin
        misaligned = 1'b0;
        wstrb_d    = 4'b0001 << req_addr[1:0];
        wdata_d    = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = req_addr[0];
        wstrb_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{req_wdata[15:0]}};
      end
      default: begin
        misaligned = |req_addr[1:0];
        wstrb_d    = 4'b1111;
        wdata_d    = req_wdata;
      end
    endcase
    if (!req_we) begin
      wstrb_d = 4'b0000;
    end
  end

  assign accept = (state_q == S_IDLE) && req_valid && !misaligned;
  assign fault  = (state_q == S_IDLE) && req_valid &&  misaligned;

  // Handshake inputs are only honoured in their own phase, so a data_ok
  // coinciding with addr_ok (or arriving while idle) is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)            state_d = S_ADDR;
      S_ADDR:  if (data_sram_addr_ok) state_d = S_DATA;
      S_DATA:  if (data_sram_data_ok) state_d = S_RESP;
      S_RESP:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      addr_q     <= 32'd0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      badvaddr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      adel_q  <= fault && !req_we;
      ades_q  <= fault &&  req_we;
      if (fault) begin
        badvaddr_q <= req_addr;
      end
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        addr_q  <= {req_addr[31:2], 2'b00};
        wstrb_q <= wstrb_d;
        wdata_q <= wdata_d;
      end
      if ((state_q == S_DATA) && data_sram_data_ok) begin
        rdata_q <= we_q ? 32'd0 : data_sram_rdata;
      end
    end
  end

  assign data_sram_req   = (state_q == S_ADDR);
  assign data_sram_wr    = we_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;

  // Released in RESP so EX can advance in the same cycle the answer appears.
  assign stallreq     = (state_q == S_ADDR) || (state_q == S_DATA) || accept;
  assign resp_valid   = (state_q == S_RESP);
  assign resp_rdata   = rdata_q;
  assign resp_size    = size_q;
  assign resp_off     = off_q;
  assign exc_adel     = adel_q;
  assign exc_ades     = ades_q;
  assign exc_badvaddr = badvaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_port
// Purpose  : Self-checking bench for data_sram_port. A transaction-level
//            model turns each request and its memory timing into per-cycle
//            expectations; one compare process checks them every cycle.
//            Directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_port;

  localparam int NC = 16384;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_size;
  logic [1:0]  resp_off;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;

  data_sram_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .stallreq(stallreq), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_size(resp_size), .resp_off(resp_off),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr)
  );

  // Per-cycle expectation record.
  typedef struct packed {
    logic        stall, req, rv, adel, ades, zero, setbad, wr, chkwd;
    logic [1:0]  sz, rsz, roff;
    logic [31:0] bad, addr, wd, rd;
    logic [3:0]  strb;
  } exp_t;

  exp_t ex [NC];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion before limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Byte enables: lane i is written when it falls in the same size-sized
  // group as the offset.
  function automatic logic [3:0] m_strb(input logic we, input logic [1:0] sz, input logic [1:0] off);
    int nb;
    int o;
    logic [3:0] s;
    s  = 4'd0;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    o  = int'(off);
    for (int i = 0; i < 4; i++) if ((i / nb) == (o / nb)) s[i] = 1'b1;
    return we ? s : 4'd0;
  endfunction

  // Lane i carries source byte (i mod access width).
  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int nb;
    logic [31:0] r;
    r  = 32'd0;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  // Compare process: every cycle from the first reset cycle onward.
  initial begin : compare
    logic [31:0] cur_bad;
    cur_bad = 32'd0;
    forever begin
      @(negedge clk);
      if (!done && cyc >= 1 && cyc < NC) begin
        if (ex[cyc].zero) cur_bad = 32'd0;
        if (ex[cyc].setbad) cur_bad = ex[cyc].bad;
        chk("stallreq", {31'd0, stallreq}, {31'd0, ex[cyc].stall});
        chk("sram_req", {31'd0, data_sram_req}, {31'd0, ex[cyc].req});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, ex[cyc].rv});
        chk("exc_adel", {31'd0, exc_adel}, {31'd0, ex[cyc].adel});
        chk("exc_ades", {31'd0, exc_ades}, {31'd0, ex[cyc].ades});
        chk("badvaddr", exc_badvaddr, cur_bad);
        if (ex[cyc].zero) begin
          chk("rst_wr", {31'd0, data_sram_wr}, 32'd0);
          chk("rst_size", {30'd0, data_sram_size}, 32'd0);
          chk("rst_addr", data_sram_addr, 32'd0);
          chk("rst_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
          chk("rst_wdata", data_sram_wdata, 32'd0);
          chk("rst_rdata", resp_rdata, 32'd0);
          chk("rst_rsize", {30'd0, resp_size}, 32'd0);
          chk("rst_roff", {30'd0, resp_off}, 32'd0);
        end
        if (ex[cyc].req) begin
          chk("sram_wr", {31'd0, data_sram_wr}, {31'd0, ex[cyc].wr});
          chk("sram_size", {30'd0, data_sram_size}, {30'd0, ex[cyc].sz});
          chk("sram_addr", data_sram_addr, ex[cyc].addr);
          chk("sram_wstrb", {28'd0, data_sram_wstrb}, {28'd0, ex[cyc].strb});
          if (ex[cyc].chkwd) chk("sram_wdata", data_sram_wdata, ex[cyc].wd);
        end
        if (ex[cyc].rv) begin
          chk("resp_rdata", resp_rdata, ex[cyc].rd);
          chk("resp_size", {30'd0, resp_size}, {30'd0, ex[cyc].rsz});
          chk("resp_off", {30'd0, resp_off}, {30'd0, ex[cyc].roff});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    data_sram_rdata = $urandom;
  endtask

  task automatic at_neg(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic busy_noise();
    req_valid = 1'($urandom % 2);
    req_we    = 1'($urandom % 2);
    req_size  = 2'($urandom % 4);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic idle(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      req_valid         = 1'b0;
      data_sram_addr_ok = noise ? 1'($urandom % 2) : 1'b0;
      data_sram_data_ok = noise ? 1'($urandom % 2) : 1'b0;
      step();
    end
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  // One request from an IDLE cycle. Records expectations, drives the
  // request and the memory side, and returns in the following IDLE cycle.
  task automatic txn(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                     input logic [31:0] wd, input int a, input int d,
                     input logic [31:0] rd, input bit stray, input bit rst_mid,
                     input bit pres_resp);
    int  t;
    int  c;
    bit  mis;
    t   = cyc;
    mis = (sz == 2'd1 && ad[0]) || (sz[1] && ad[1:0] != 2'b00);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = ad; req_wdata = wd;
    data_sram_addr_ok = 1'($urandom % 2);
    data_sram_data_ok = 1'($urandom % 2);
    if (mis) begin
      ex[t+1].adel   = !we;
      ex[t+1].ades   = we;
      ex[t+1].setbad = 1'b1;
      ex[t+1].bad    = ad;
      step();
      req_valid = 1'b0;
      step();
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      return;
    end
    ex[t].stall = 1'b1;
    for (int k = 0; k <= a; k++) begin
      c = t + 1 + k;
      ex[c].stall = 1'b1; ex[c].req = 1'b1; ex[c].wr = we; ex[c].sz = sz;
      ex[c].addr  = {ad[31:2], 2'b00};
      ex[c].strb  = m_strb(we, sz, ad[1:0]);
      ex[c].wd    = m_wdata(sz, wd);
      ex[c].chkwd = we;
      step();
      busy_noise();
      data_sram_addr_ok = (k == a);
      data_sram_data_ok = (k == a) ? stray : 1'($urandom % 2);
    end
    for (int k = 0; k <= d; k++) begin
      c = t + 2 + a + k;
      ex[c].stall = 1'b1;
      step();
      busy_noise();
      data_sram_addr_ok = 1'($urandom % 2);
      data_sram_data_ok = (k == d);
      if (k == d) data_sram_rdata = rd;
      if (rst_mid) begin
        data_sram_data_ok = 1'b0;
        rst = 1'b1;
        ex[c+1].zero = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
        return;
      end
    end
    c = t + 3 + a + d;
    ex[c].rv   = 1'b1;
    ex[c].rd   = we ? 32'd0 : rd;
    ex[c].rsz  = sz;
    ex[c].roff = ad[1:0];
    step();
    busy_noise();
    req_valid = pres_resp;
    data_sram_addr_ok = 1'($urandom % 2);
    data_sram_data_ok = 1'($urandom % 2);
    step();
    req_valid = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  initial begin : main
    int t;
    for (int i = 0; i < NC; i++) ex[i] = '0;
    ex[1].zero = 1'b1;
    ex[2].zero = 1'b1;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    step();
    step();
    rst = 1'b0;
    idle(2, 1'b0);

    // sb at 0x1003
    t = cyc;
    fork
      txn(1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      begin
        at_neg(t + 1);
        chk("sb_addr", data_sram_addr, 32'h0000_1000);
        chk("sb_wstrb", {28'd0, data_sram_wstrb}, 32'h8);
        chk("sb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
        chk("sb_wr", {31'd0, data_sram_wr}, 32'd1);
        at_neg(t + 3);
        chk("sb_rv", {31'd0, resp_valid}, 32'd1);
        chk("sb_rdata", resp_rdata, 32'd0);
        chk("sb_off", {30'd0, resp_off}, 32'd3);
      end
    join

    // lh at 0x2002 with wait states
    t = cyc;
    fork
      txn(1'b0, 2'd1, 32'h0000_2002, 32'h0, 2, 2, 32'h8001_BEEF, 1'b0, 1'b0, 1'b0);
      begin
        at_neg(t + 2);
        chk("lh_stall_addr", {31'd0, stallreq}, 32'd1);
        at_neg(t + 5);
        chk("lh_stall_data", {31'd0, stallreq}, 32'd1);
        at_neg(t + 7);
        chk("lh_rv", {31'd0, resp_valid}, 32'd1);
        chk("lh_rdata", resp_rdata, 32'h8001_BEEF);
        chk("lh_size", {30'd0, resp_size}, 32'd1);
        chk("lh_off", {30'd0, resp_off}, 32'd2);
      end
    join

    // misaligned lw and sh
    t = cyc;
    fork
      txn(1'b0, 2'd2, 32'h0000_3002, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      begin
        at_neg(t);
        chk("lw_mis_stall", {31'd0, stallreq}, 32'd0);
        at_neg(t + 1);
        chk("lw_mis_adel", {31'd0, exc_adel}, 32'd1);
        chk("lw_mis_bad", exc_badvaddr, 32'h0000_3002);
        chk("lw_mis_req", {31'd0, data_sram_req}, 32'd0);
      end
    join
    t = cyc;
    fork
      txn(1'b1, 2'd1, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      begin
        at_neg(t + 1);
        chk("sh_mis_ades", {31'd0, exc_ades}, 32'd1);
        chk("sh_mis_adel", {31'd0, exc_adel}, 32'd0);
        chk("sh_mis_bad", exc_badvaddr, 32'h0000_3001);
      end
    join

    // stray data_ok while idle
    t = cyc;
    data_sram_data_ok = 1'b1;
    step();
    step();
    data_sram_data_ok = 1'b0;
    step();
    chk("stray_idle_rv", {31'd0, resp_valid}, 32'd0);

    // data_ok coinciding with addr_ok is ignored
    t = cyc;
    fork
      txn(1'b0, 2'd2, 32'h0000_0500, 32'h0, 0, 1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
      begin
        at_neg(t + 3);
        chk("same_cyc_rv_early", {31'd0, resp_valid}, 32'd0);
        at_neg(t + 4);
        chk("same_cyc_rv", {31'd0, resp_valid}, 32'd1);
        chk("same_cyc_rdata", resp_rdata, 32'hCAFE_0001);
      end
    join

    // reset in DATA, then sw
    t = cyc;
    fork
      txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 1, 2, 32'h0, 1'b0, 1'b1, 1'b0);
      begin
        at_neg(t + 4);
        chk("rst_mid_rv", {31'd0, resp_valid}, 32'd0);
        chk("rst_mid_stall", {31'd0, stallreq}, 32'd0);
      end
    join
    t = cyc;
    fork
      txn(1'b1, 2'd2, 32'h0000_0040, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      begin
        at_neg(t + 1);
        chk("sw_wstrb", {28'd0, data_sram_wstrb}, 32'hF);
        chk("sw_wdata", data_sram_wdata, 32'h1234_5678);
      end
    join

    // back-to-back lw then sw, zero wait states
    t = cyc;
    fork
      begin
        txn(1'b0, 2'd2, 32'h0000_0600, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 1'b0, 1'b1);
        txn(1'b1, 2'd2, 32'h0000_0604, 32'h3333_4444, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      end
      begin
        at_neg(t + 3);
        chk("b2b_rv1", {31'd0, resp_valid}, 32'd1);
        at_neg(t + 4);
        chk("b2b_req_gap", {31'd0, data_sram_req}, 32'd0);
        at_neg(t + 5);
        chk("b2b_req2", {31'd0, data_sram_req}, 32'd1);
        at_neg(t + 7);
        chk("b2b_rv2", {31'd0, resp_valid}, 32'd1);
      end
    join

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [1:0]  sz;
      logic [31:0] ad;
      we = 1'($urandom % 2);
      sz = 2'($urandom % 4);
      ad = $urandom;
      if ($urandom % 4 != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz[1]) ad[1:0] = 2'b00;
      end
      txn(we, sz, ad, $urandom, int'($urandom % 4), int'($urandom % 4), $urandom,
          ($urandom % 4) == 0, ($urandom % 25) == 0, 1'($urandom % 2));
      idle(int'($urandom % 3), 1'b1);
    end

    idle(2, 1'b0);
    done = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
